// File: rtl/credit_latency_decoupler.sv
// Credit-based decoupler between a fixed-latency external pipeline and a ready/valid consumer.
// Optional status outputs (occupancy, overflow) are enabled by CREDIT_LATENCY_DECOUPLER_STATUS_EN.
module credit_latency_decoupler #(
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] pipe_data,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] r_vpipe;
  logic [IW-1:0]      r_in_flight;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic               r_run;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_issue;
  logic               w_wr;
  logic               w_pop;
  logic               w_full;
  logic [PW-1:0]      w_occ;
  logic [31:0]        w_used;

  assign w_occ      = r_wptr - r_rptr;
  assign w_full     = (w_occ == PW'(DEPTH));
  assign w_issue    = din_valid & din_ready;
  assign w_wr       = r_vpipe[LATENCY-1];
  assign w_pop      = dout_valid & dout_ready;
  // Credits come only from registered state, so a pop is visible to din_ready one cycle later.
  assign w_used     = 32'(r_in_flight) + 32'(w_occ);
  assign din_ready  = r_run & (w_used < 32'(DEPTH));
  assign dout_valid = (w_occ != '0);
  assign dout_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpipe     <= '0;
      r_in_flight <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_run       <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_vpipe[0] <= w_issue;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
      case ({w_issue, w_wr})
        2'b10:   r_in_flight <= r_in_flight + IW'(1);
        2'b01:   r_in_flight <= r_in_flight - IW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
      if (w_wr && !w_full) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr && !w_full) begin
      r_mem[r_wptr[AW-1:0]] <= pipe_data;
    end
  end

`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign occupancy = w_occ;
  assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_credit_latency_decoupler.sv
// Directed bench for credit_latency_decoupler: latency, fill/credit, throughput, reset discard, random stress.
module tb_credit_latency_decoupler;

  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] pipe_data = '0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
  logic [3:0]    occupancy;
  logic          overflow;
`endif

  always #5 clk = ~clk;

  credit_latency_decoupler #(.DATA_W(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .pipe_data  (pipe_data),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
    ,
    .occupancy  (occupancy),
    .overflow   (overflow)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // External pipeline (never reset) and the expected-state model of the block.
  logic [DW-1:0] dl [LAT];
  bit            mv [LAT];
  logic [DW-1:0] exp_q [$];
  int            occ_m = 0;
  int            infl_m = 0;
  bit            run_m = 0;
  logic [DW-1:0] next_tag = 16'h0100;
  int            n_acc = 0;
  int            n_pop = 0;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit acc, pop, wr;
    bit exp_rdy;
    exp_rdy = run_m && ((infl_m + occ_m) < DEP);
    chk("din_ready", 32'(din_ready), 32'(exp_rdy));
    chk("dout_valid", 32'(dout_valid), 32'(occ_m != 0));
    if (occ_m != 0 && dout_valid) chk("dout_data", 32'(dout_data), 32'(exp_q[0]));
    acc = din_valid && din_ready;
    pop = dout_valid && dout_ready;
    wr  = mv[LAT-1];
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wr) exp_q.push_back(dl[LAT-1]);
    infl_m = infl_m + int'(acc) - int'(wr);
    occ_m  = occ_m + int'(wr) - int'(pop);
    for (int i = LAT - 1; i > 0; i--) begin
      mv[i] = mv[i-1];
      dl[i] = dl[i-1];
    end
    mv[0] = acc;
    dl[0] = acc ? next_tag : 16'hDEAD;
    if (acc) begin
      next_tag = next_tag + 16'd1;
      n_acc++;
    end
    if (pop) n_pop++;
    @(posedge clk);
    #1;
    run_m = 1;
    pipe_data = dl[LAT-1];
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    occ_m  = 0;
    infl_m = 0;
    run_m  = 0;
    for (int i = 0; i < LAT; i++) mv[i] = 0;
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_valid", 32'(dout_valid), 32'd0);
      chk("rst_hold_ready", 32'(din_ready), 32'd0);
    end
    rst = 1'b1;
  endtask

  initial begin
    int a0, p0, t0;
    for (int i = 0; i < LAT; i++) begin
      dl[i] = 16'hDEAD;
      mv[i] = 0;
    end

    // Reset state and release
    do_reset();
    cycle();
    chk("ready_after_rst", 32'(din_ready), 32'd1);

    // Single issue latency: issue -> dout_valid after LATENCY+1 cycles
    dout_ready = 1'b1;
    next_tag   = 16'h00A5;
    din_valid  = 1'b1;
    t0 = cyc;
    cycle();
    din_valid = 1'b0;
    for (int k = 0; k < 10 && !dout_valid; k++) cycle();
    chk("lat_valid", 32'(dout_valid), 32'd1);
    chk("lat_cycles", 32'(cyc - t0), 32'd4);
    chk("lat_data", 32'(dout_data), 32'h00A5);
    repeat (3) cycle();

    // Fill with downstream stalled: exactly DEPTH accepted, then blocked
    next_tag   = 16'h0200;
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    a0 = n_acc;
    repeat (20) cycle();
    chk("fill_accepts", 32'(n_acc - a0), 32'd8);
    chk("fill_ready_low", 32'(din_ready), 32'd0);
    chk("fill_head", 32'(dout_data), 32'h0200);
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
    chk("fill_occupancy", 32'(occupancy), 32'd8);
    chk("fill_overflow", 32'(overflow), 32'd0);
`endif

    // One pop frees exactly one credit
    a0 = n_acc;
    dout_ready = 1'b1;
    cycle();
    dout_ready = 1'b0;
    chk("credit_ready", 32'(din_ready), 32'd1);
    repeat (10) cycle();
    chk("credit_accepts", 32'(n_acc - a0), 32'd1);
    chk("credit_head", 32'(dout_data), 32'h0201);

    // Drain: 8 remaining entries in order
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    p0 = n_pop;
    repeat (15) cycle();
    chk("drain_count", 32'(n_pop - p0), 32'd8);
    chk("drain_empty", 32'(dout_valid), 32'd0);

    // Full throughput: 100 back-to-back issues, no bubbles
    a0 = n_acc;
    p0 = n_pop;
    din_valid = 1'b1;
    repeat (100) cycle();
    din_valid = 1'b0;
    chk("tput_accepts", 32'(n_acc - a0), 32'd100);
    chk("tput_pops_mid", 32'(n_pop - p0), 32'd96);
    repeat (4) cycle();
    chk("tput_pops_end", 32'(n_pop - p0), 32'd100);
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
    chk("tput_occupancy", 32'(occupancy), 32'd0);
`endif

    // Reset mid-operation: 2 buffered + 3 in flight, all discarded
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    repeat (5) cycle();
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    din_valid = 1'b0;
    do_reset();
    dout_ready = 1'b1;
    p0 = n_pop;
    repeat (10) cycle();
    chk("post_rst_pops", 32'(n_pop - p0), 32'd0);
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
    chk("post_rst_overflow", 32'(overflow), 32'd0);
`endif

    // Random traffic with per-cycle credit and order checks
    a0 = n_acc;
    p0 = n_pop;
    repeat (10000) begin
      din_valid  = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (20) cycle();
    chk("rand_no_loss", 32'(n_pop - p0), 32'(n_acc - a0));
    chk("rand_empty", 32'(dout_valid), 32'd0);
`ifdef CREDIT_LATENCY_DECOUPLER_STATUS_EN
    chk("rand_overflow", 32'(overflow), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
